// File: rtl/contador_control_pkg.sv
// Shared definitions for the counter sequencing controller: mode encoding and count width.
// Pure declarations; no timing or flow control of its own.
package contador_control_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_LOAD   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_MANUAL: return MODE_AUTO;
      MODE_AUTO:   return MODE_LOAD;
      MODE_LOAD:   return MODE_HOLD;
      default:     return MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/detector_flanco_pulso.sv
// Two-flop synchroniser plus history flop; emits a registered one-cycle pulse per rising edge.
// A level sampled at edge k pulses after edge k+2; no backpressure, held levels pulse once.
module detector_flanco_pulso (
  input  logic iClk,
  input  logic iReset,
  input  logic iIn,
  output logic oPulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic r_pulse;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= iIn;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_pulse <= r_sync2 & ~r_hist;
    end
  end

  assign oPulse = r_pulse;

endmodule

// File: rtl/contador_control.sv
// Button-driven mode FSM (MANUAL/AUTO/LOAD/HOLD) controlling an 8-bit counter with wrap/saturate flags.
// Button to count update takes 3 edges after sampling; no backpressure, all outputs registered.
module contador_control
  import contador_control_pkg::*;
#(
  parameter int PRESCALE = 50000000,
  parameter int PRE_W    = 26,
  parameter int WRAP     = 1
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iBtnUp,
  input  logic               iBtnDown,
  input  logic               iBtnMode,
  input  logic [COUNT_W-1:0] iData,
  output logic [COUNT_W-1:0] oCount,
  output logic [1:0]         oMode,
  output logic               oDir,
  output logic               oOverflow,
  output logic               oUnderflow
);

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  logic               w_up_p;
  logic               w_dn_p;
  logic               w_mode_p;
  logic               w_at_max;
  logic               w_at_min;
  logic [COUNT_W-1:0] w_cnt_inc;
  logic [COUNT_W-1:0] w_cnt_dec;

  logic [COUNT_W-1:0] r_count;
  mode_t              r_mode;
  logic               r_dir;
  logic               r_ovf;
  logic               r_unf;
  logic [PRE_W-1:0]   r_pre;

  detector_flanco_pulso u_det_up   (.iClk(iClk), .iReset(iReset), .iIn(iBtnUp),   .oPulse(w_up_p));
  detector_flanco_pulso u_det_down (.iClk(iClk), .iReset(iReset), .iIn(iBtnDown), .oPulse(w_dn_p));
  detector_flanco_pulso u_det_mode (.iClk(iClk), .iReset(iReset), .iIn(iBtnMode), .oPulse(w_mode_p));

  // Flags fire on any step past the limit, whether the count wraps or saturates.
  assign w_at_max  = (r_count == CNT_MAX);
  assign w_at_min  = (r_count == '0);
  assign w_cnt_inc = w_at_max ? ((WRAP != 0) ? '0 : CNT_MAX) : r_count + 1'b1;
  assign w_cnt_dec = w_at_min ? ((WRAP != 0) ? CNT_MAX : '0) : r_count - 1'b1;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_count <= '0;
      r_mode  <= MODE_MANUAL;
      r_dir   <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_pre   <= '0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (w_mode_p) begin
        r_mode <= next_mode(r_mode);
        r_pre  <= '0;
      end else begin
        case (r_mode)
          MODE_MANUAL: begin
            if (w_up_p && !w_dn_p) begin
              r_count <= w_cnt_inc;
              r_ovf   <= w_at_max;
            end else if (w_dn_p && !w_up_p) begin
              r_count <= w_cnt_dec;
              r_unf   <= w_at_min;
            end
          end
          MODE_AUTO: begin
            // A button pulse takes precedence over a coincident terminal count.
            if (w_up_p || w_dn_p) begin
              if (w_up_p ^ w_dn_p) begin
                r_dir <= w_up_p;
                r_pre <= '0;
              end
            end else if (r_pre == PRE_LAST) begin
              r_pre <= '0;
              if (r_dir) begin
                r_count <= w_cnt_inc;
                r_ovf   <= w_at_max;
              end else begin
                r_count <= w_cnt_dec;
                r_unf   <= w_at_min;
              end
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          MODE_LOAD: begin
            if (w_up_p) begin
              r_count <= iData;
            end else if (w_dn_p) begin
              r_count <= '0;
            end
          end
          default: begin
            r_pre <= '0;
          end
        endcase
      end
    end
  end

  assign oCount     = r_count;
  assign oMode      = r_mode;
  assign oDir       = r_dir;
  assign oOverflow  = r_ovf;
  assign oUnderflow = r_unf;

endmodule

// File: tb/tb_contador_control.sv
// Directed bench for contador_control: a wrapping and a saturating instance share one stimulus stream,
// expected outputs are queued as each step is driven and compared once the update edge has passed.
module tb_contador_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       up;
  logic       dn;
  logic       md;
  logic [7:0] data;

  logic [7:0] cnt_a, cnt_b;
  logic [1:0] mode_a, mode_b;
  logic       dir_a, dir_b, ovf_a, ovf_b, unf_a, unf_b;

  always #5 clk = ~clk;

  contador_control #(.PRESCALE(4), .PRE_W(3), .WRAP(1)) u_a (
    .iClk(clk), .iReset(rst), .iBtnUp(up), .iBtnDown(dn), .iBtnMode(md), .iData(data),
    .oCount(cnt_a), .oMode(mode_a), .oDir(dir_a), .oOverflow(ovf_a), .oUnderflow(unf_a)
  );

  contador_control #(.PRESCALE(4), .PRE_W(3), .WRAP(0)) u_b (
    .iClk(clk), .iReset(rst), .iBtnUp(up), .iBtnDown(dn), .iBtnMode(md), .iData(data),
    .oCount(cnt_b), .oMode(mode_b), .oDir(dir_b), .oOverflow(ovf_b), .oUnderflow(unf_b)
  );

  typedef struct {
    logic [7:0] ca;
    logic [7:0] cb;
    logic [1:0] mode;
    logic       dir;
    logic       oa;
    logic       ua;
    logic       ob;
    logic       ub;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] ca, input logic [7:0] cb,
                      input logic [1:0] m, input logic d,
                      input logic oa, input logic ua, input logic ob, input logic ub);
    exp_t e;
    e.ca = ca; e.cb = cb; e.mode = m; e.dir = d;
    e.oa = oa; e.ua = ua; e.ob = ob; e.ub = ub;
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t  e;
    string t;
    n_chk++;
    assert (q_exp.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", q_exp.size());
    end
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      cmp(t, "count_a", cnt_a, e.ca);
      cmp(t, "count_b", cnt_b, e.cb);
      cmp(t, "mode_a", 8'(mode_a), 8'(e.mode));
      cmp(t, "mode_b", 8'(mode_b), 8'(e.mode));
      cmp(t, "dir_a", 8'(dir_a), 8'(e.dir));
      cmp(t, "dir_b", 8'(dir_b), 8'(e.dir));
      cmp(t, "ovf_a", 8'(ovf_a), 8'(e.oa));
      cmp(t, "unf_a", 8'(unf_a), 8'(e.ua));
      cmp(t, "ovf_b", 8'(ovf_b), 8'(e.ob));
      cmp(t, "unf_b", 8'(unf_b), 8'(e.ub));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Level held for one sampling edge, then three more edges to reach the update edge.
  task automatic press(input logic u, input logic d, input logic m);
    up = u; dn = d; md = m;
    tick(1);
    up = 1'b0; dn = 1'b0; md = 1'b0;
    tick(3);
  endtask

  initial begin
    rst = 1'b1; up = 1'b0; dn = 1'b0; md = 1'b0; data = 8'h00;

    push("reset", 8'h00, 8'h00, 2'd0, 1'b1, 0, 0, 0, 0);
    tick(2);
    check_pop();
    rst = 1'b0;
    tick(2);

    // Held up button: one pulse, count changes on the third edge after sampling.
    push("t1_pre", 8'h00, 8'h00, 2'd0, 1'b1, 0, 0, 0, 0);
    up = 1'b1;
    tick(3);
    check_pop();
    push("t1_step", 8'h01, 8'h01, 2'd0, 1'b1, 0, 0, 0, 0);
    tick(1);
    check_pop();
    push("t1_held", 8'h01, 8'h01, 2'd0, 1'b1, 0, 0, 0, 0);
    tick(6);
    up = 1'b0;
    tick(4);
    check_pop();

    push("t5_updn", 8'h01, 8'h01, 2'd0, 1'b1, 0, 0, 0, 0);
    press(1, 1, 0);
    check_pop();
    push("t5_mode_up", 8'h01, 8'h01, 2'd1, 1'b1, 0, 0, 0, 0);
    press(1, 0, 1);
    check_pop();

    // AUTO with PRESCALE=4: steps 4, 8 and 12 cycles after entry.
    push("t3_auto11", 8'h03, 8'h03, 2'd1, 1'b1, 0, 0, 0, 0);
    tick(11);
    check_pop();
    push("t3_auto12", 8'h04, 8'h04, 2'd1, 1'b1, 0, 0, 0, 0);
    tick(1);
    check_pop();
    push("t3_down", 8'h04, 8'h04, 2'd1, 1'b0, 0, 0, 0, 0);
    press(0, 1, 0);
    check_pop();
    push("t3_pre3", 8'h04, 8'h04, 2'd1, 1'b0, 0, 0, 0, 0);
    tick(3);
    check_pop();
    push("t3_step_dn", 8'h03, 8'h03, 2'd1, 1'b0, 0, 0, 0, 0);
    tick(1);
    check_pop();

    push("t4_load_mode", 8'h03, 8'h03, 2'd2, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    data = 8'hA5;
    push("t4_load", 8'hA5, 8'hA5, 2'd2, 1'b0, 0, 0, 0, 0);
    press(1, 0, 0);
    check_pop();
    push("t4_clear", 8'h00, 8'h00, 2'd2, 1'b0, 0, 0, 0, 0);
    press(0, 1, 0);
    check_pop();

    data = 8'hFF;
    push("t2_load_ff", 8'hFF, 8'hFF, 2'd2, 1'b0, 0, 0, 0, 0);
    press(1, 0, 0);
    check_pop();
    push("t2_hold", 8'hFF, 8'hFF, 2'd3, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    push("t2_hold_up", 8'hFF, 8'hFF, 2'd3, 1'b0, 0, 0, 0, 0);
    press(1, 0, 0);
    check_pop();
    push("t2_manual", 8'hFF, 8'hFF, 2'd0, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    push("t2_ovf", 8'h00, 8'hFF, 2'd0, 1'b0, 1, 0, 1, 0);
    press(1, 0, 0);
    check_pop();
    push("t2_ovf_clr", 8'h00, 8'hFF, 2'd0, 1'b0, 0, 0, 0, 0);
    tick(1);
    check_pop();
    push("t2_unf", 8'hFF, 8'hFE, 2'd0, 1'b0, 0, 1, 0, 0);
    press(0, 1, 0);
    check_pop();
    push("t2_unf_clr", 8'hFF, 8'hFE, 2'd0, 1'b0, 0, 0, 0, 0);
    tick(1);
    check_pop();

    // Back-to-back mode presses through AUTO land on the terminal edge and suppress the step.
    push("t6_auto", 8'hFF, 8'hFE, 2'd1, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    push("t6_load_mode", 8'hFF, 8'hFE, 2'd2, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    data = 8'h07;
    push("t6_load7", 8'h07, 8'h07, 2'd2, 1'b0, 0, 0, 0, 0);
    press(1, 0, 0);
    check_pop();
    push("t6_hold", 8'h07, 8'h07, 2'd3, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    push("t6_manual", 8'h07, 8'h07, 2'd0, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();
    push("t6_auto_run", 8'h07, 8'h07, 2'd1, 1'b0, 0, 0, 0, 0);
    press(0, 0, 1);
    check_pop();

    // Reset lands on a terminal-count edge with an up pulse in flight.
    tick(2);
    up = 1'b1;
    tick(1);
    up = 1'b0;
    rst = 1'b1;
    push("t6_reset", 8'h00, 8'h00, 2'd0, 1'b1, 0, 0, 0, 0);
    tick(1);
    check_pop();
    rst = 1'b0;
    push("t6_no_residual", 8'h00, 8'h00, 2'd0, 1'b1, 0, 0, 0, 0);
    tick(8);
    check_pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
